counter_seq_checker: RTL and testbench
======================================

// Module: counter_seq_checker
// PURPOSE
//  Receive-side monitor for the 3-run/2-pause 4-bit counter (sequence 0,2,4,5,7,9).
//  Observes the counter value q, enable en and even/odd select oe, then locks to the pattern.
//  Checks every step, every held value and the run/pause timing. Reports lap progress and errors.
//  Sits beside the counter as a self-check block and drives the board status LEDs.
// PARAMETERS
//  RUN_LAPS    3  laps of 6 steps per run phase (1..3)
//  PAUSE_LAPS  2  pause length in laps; pause = PAUSE_LAPS*6 cycles with en low (1..4)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  synchronous, active-high reset
//  q          in   4  counter value under test
//  en         in   1  counter enable under test
//  oe         in   1  counter even/odd select under test
//  locked     out  1  1 = aligned to the sequence (RUN or PAUSE)
//  phase      out  1  1 = run, 0 = pause or unlocked
//  lap_cnt    out  2  completed laps in the current run phase
//  lap_done   out  1  one-cycle pulse on each completed lap
//  cycle_done out  1  one-cycle pulse when a pause completes correctly
//  err        out  1  one-cycle pulse on a detected violation
//  err_code   out  2  1 = value mismatch, 2 = oe mismatch, 3 = enable/timing violation; held until next err
//  err_cnt    out  8  error count, saturates at 255
// BEHAVIOUR
//  - Reset: all outputs 0; state SYNC; idx=0; pause_cnt=0. Reset mid-operation has the same effect at the next edge.
//  - Inputs are registered once (q_r, en_r, oe_r). All outputs are registered.
//    An event present at the ports in cycle t appears on the outputs in cycle t+2.
//  - A cycle with en_r=1 is a step. Expected values: SEQ[idx] = {0,2,4,5,7,9}.
//    Expected oe is 0 for idx 0..2 and 1 for idx 3..5.
//  - SYNC state: move to RUN when a step has q_r=0 and oe_r=0; set idx=1 and lap_cnt=0.
//    Otherwise stay in SYNC. No err is raised in SYNC.
//  - RUN state, per cycle:
//    . en_r=0: err, code 3.
//    . q_r != SEQ[idx]: err, code 1.
//    . oe_r wrong: err, code 2.
//    . Priority when several apply: code 3, then code 1, then code 2.
//    . Correct step: idx = idx+1. At idx=5, wrap idx to 0, pulse lap_done and increment lap_cnt.
//    . When lap_cnt reaches RUN_LAPS: go to PAUSE, set pause_cnt=0, set lap_cnt=0.
//  - PAUSE state, per cycle:
//    . en_r=1: err, code 3.
//    . q_r != 9: err, code 1.
//    . Otherwise pause_cnt increments.
//    . When pause_cnt = PAUSE_LAPS*6-1 and the cycle is correct: pulse cycle_done, go to RUN, set idx=0.
//      The next cycle must be a step with q=0.
//  - Any err: go to SYNC, set locked=0 and phase=0, increment err_cnt (saturating at 255).
//    lap_cnt holds its value in SYNC and clears on relock.
//  - Width rules: idx is 3 bits and never exceeds 5. pause_cnt is 5 bits. lap_cnt is 2 bits.
// STRUCTURE
//  - Shared package counter_seq_pkg holds:
//    . SEQ_LEN=6, ODD_START_IDX=3, LAST_VAL=4'd9
//    . function seq_val(idx), returns 4 bits
//    . state encodings ST_SYNC / ST_RUN / ST_PAUSE
//    . error codes ERR_VAL / ERR_OE / ERR_EN
//  - The counter already uses these constants.
//  - One sub-module: seq_step_cmp (combinational). Inputs idx, q_r, oe_r; outputs val_ok and oe_ok.
//  - FSM and counters live in the top-level module.
// TESTING
//  - Reset, then a golden counter for 3 laps + 12 pause cycles + 1 lap. Expect:
//    . locked at t+2 after first q=0 step
//    . lap_done x4, cycle_done x1
//    . err never asserted; err_cnt=0
//  - Corrupt one step (q=6 instead of 4) in lap 2. Expect err=1 and err_code=1 two cycles later.
//    Expect locked=0 and err_cnt=1, then relock at the next q=0 step.
//  - Force oe=1 while q=4. Expect err_code=2.
//  - Force q=4 and oe=1 together. Expect err_code=1 (priority rule).
//  - Start the pause after 11 cycles (en=1 early). Expect err_code=3 and no cycle_done.
//    Drop en for 1 cycle mid-run. Expect err_code=3.
//  - Inject 300 errors. Expect err_cnt saturates at 255.
//    Assert reset mid-pause. Expect all outputs 0 next cycle and relock on the next q=0 step.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared constants for the 3-run/2-pause counter and its checker.
package counter_seq_pkg;

  localparam int         SEQ_LEN       = 6;
  localparam logic [2:0] ODD_START_IDX = 3'd3;
  localparam logic [3:0] LAST_VAL      = 4'd9;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } st_t;

  localparam logic [1:0] ERR_VAL = 2'd1;
  localparam logic [1:0] ERR_OE  = 2'd2;
  localparam logic [1:0] ERR_EN  = 2'd3;

  // Counter value expected at sequence position idx (0,2,4,5,7,9).
  function automatic logic [3:0] seq_val(input logic [2:0] idx);
    case (idx)
      3'd0:    seq_val = 4'd0;
      3'd1:    seq_val = 4'd2;
      3'd2:    seq_val = 4'd4;
      3'd3:    seq_val = 4'd5;
      3'd4:    seq_val = 4'd7;
      3'd5:    seq_val = LAST_VAL;
      default: seq_val = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/counter_seq_checker_seq_step_cmp.sv
// Combinational compare of one observed step against the expected sequence slot.
module seq_step_cmp
  import counter_seq_pkg::*;
(
  input  logic [2:0] idx,
  input  logic [3:0] q_r,
  input  logic       oe_r,
  output logic       val_ok,
  output logic       oe_ok
);

  // Odd half of the sequence (idx 3..5) is produced with oe high.
  assign val_ok = (q_r == seq_val(idx));
  assign oe_ok  = (oe_r == (idx >= ODD_START_IDX));

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side monitor: locks to the counter sequence, checks steps, run/pause
// timing, and reports lap progress and errors. Inputs registered once, outputs
// registered, so port events show on outputs two cycles later.
module counter_seq_checker
  import counter_seq_pkg::*;
#(
  parameter int RUN_LAPS   = 3,
  parameter int PAUSE_LAPS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q,
  input  logic       en,
  input  logic       oe,
  output logic       locked,
  output logic       phase,
  output logic [1:0] lap_cnt,
  output logic       lap_done,
  output logic       cycle_done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [7:0] err_cnt
);

  localparam logic [2:0] LAST_IDX   = 3'(SEQ_LEN - 1);
  localparam logic [1:0] LAP_LAST   = 2'(RUN_LAPS - 1);
  localparam logic [4:0] PAUSE_LAST = 5'(PAUSE_LAPS * SEQ_LEN - 1);

  logic [3:0] q_r;
  logic       en_r, oe_r;
  st_t        state, state_n;
  logic [2:0] idx, idx_n;
  logic [4:0] pause_cnt, pause_cnt_n;
  logic [1:0] lap_cnt_n, err_code_n;
  logic [7:0] err_cnt_n;
  logic       lap_done_n, cycle_done_n, err_n;
  logic       val_ok, oe_ok;

  seq_step_cmp u_cmp (
    .idx    (idx),
    .q_r    (q_r),
    .oe_r   (oe_r),
    .val_ok (val_ok),
    .oe_ok  (oe_ok)
  );

  // Input capture, FSM state, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_r        <= '0;
      en_r       <= 1'b0;
      oe_r       <= 1'b0;
      state      <= ST_SYNC;
      idx        <= '0;
      pause_cnt  <= '0;
      locked     <= 1'b0;
      phase      <= 1'b0;
      lap_cnt    <= '0;
      lap_done   <= 1'b0;
      cycle_done <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      err_cnt    <= '0;
    end else begin
      q_r        <= q;
      en_r       <= en;
      oe_r       <= oe;
      state      <= state_n;
      idx        <= idx_n;
      pause_cnt  <= pause_cnt_n;
      locked     <= (state_n != ST_SYNC);
      phase      <= (state_n == ST_RUN);
      lap_cnt    <= lap_cnt_n;
      lap_done   <= lap_done_n;
      cycle_done <= cycle_done_n;
      err        <= err_n;
      err_code   <= err_code_n;
      err_cnt    <= err_cnt_n;
    end
  end

  // Next-state: lock in SYNC, step/lap tracking in RUN, hold timing in PAUSE.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    pause_cnt_n  = pause_cnt;
    lap_cnt_n    = lap_cnt;
    lap_done_n   = 1'b0;
    cycle_done_n = 1'b0;
    err_n        = 1'b0;
    err_code_n   = err_code;
    err_cnt_n    = err_cnt;
    case (state)
      ST_SYNC: begin
        if (en_r && q_r == seq_val(3'd0) && !oe_r) begin
          state_n   = ST_RUN;
          idx_n     = 3'd1;
          lap_cnt_n = '0;
        end
      end
      ST_RUN: begin
        if (!en_r) begin
          err_n = 1'b1; err_code_n = ERR_EN;
        end else if (!val_ok) begin
          err_n = 1'b1; err_code_n = ERR_VAL;
        end else if (!oe_ok) begin
          err_n = 1'b1; err_code_n = ERR_OE;
        end else if (idx == LAST_IDX) begin
          idx_n      = '0;
          lap_done_n = 1'b1;
          if (lap_cnt == LAP_LAST) begin
            state_n     = ST_PAUSE;
            pause_cnt_n = '0;
            lap_cnt_n   = '0;
          end else begin
            lap_cnt_n = lap_cnt + 2'd1;
          end
        end else begin
          idx_n = idx + 3'd1;
        end
      end
      ST_PAUSE: begin
        if (en_r) begin
          err_n = 1'b1; err_code_n = ERR_EN;
        end else if (q_r != LAST_VAL) begin
          err_n = 1'b1; err_code_n = ERR_VAL;
        end else if (pause_cnt == PAUSE_LAST) begin
          cycle_done_n = 1'b1;
          state_n      = ST_RUN;
          idx_n        = '0;
          pause_cnt_n  = '0;
        end else begin
          pause_cnt_n = pause_cnt + 5'd1;
        end
      end
      default: state_n = ST_SYNC;
    endcase
    // Any violation drops lock; lap_cnt is left as-is until relock.
    if (err_n) begin
      state_n = ST_SYNC;
      idx_n   = '0;
      if (err_cnt != 8'hFF) err_cnt_n = err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_counter_seq_checker.sv
// Directed bench for counter_seq_checker: golden sequence, injected faults,
// saturation and mid-pause reset.
module tb_counter_seq_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q = '0;
  logic       en = 1'b0;
  logic       oe = 1'b0;
  logic       locked, phase, lap_done, cycle_done, err;
  logic [1:0] lap_cnt, err_code;
  logic [7:0] err_cnt;

  counter_seq_checker dut (
    .clk(clk), .reset(reset), .q(q), .en(en), .oe(oe),
    .locked(locked), .phase(phase), .lap_cnt(lap_cnt), .lap_done(lap_done),
    .cycle_done(cycle_done), .err(err), .err_code(err_code), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [3:0] seq_tb [6] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9};

  logic       c_locked, c_phase, c_lap_done, c_cycle_done, c_err;
  logic [1:0] c_lap_cnt, c_err_code;
  logic [7:0] c_err_cnt;
  int n_lap_done, n_cycle_done, n_err;

  // One cycle: capture outputs (they reflect the vector driven two calls ago),
  // then apply the next vector.
  task automatic cyc(input logic r, input logic [3:0] qv, input logic ev, input logic ov);
    @(negedge clk);
    c_locked = locked; c_phase = phase; c_lap_cnt = lap_cnt;
    c_lap_done = lap_done; c_cycle_done = cycle_done;
    c_err = err; c_err_code = err_code; c_err_cnt = err_cnt;
    if (c_lap_done === 1'b1) n_lap_done++;
    if (c_cycle_done === 1'b1) n_cycle_done++;
    if (c_err === 1'b1) n_err++;
    reset = r; q = qv; en = ev; oe = ov;
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    n_lap_done = 0; n_cycle_done = 0; n_err = 0;
  endtask

  task automatic lap();
    for (int i = 0; i < 6; i++) cyc(0, seq_tb[i], 1'b1, (i >= 3));
  endtask

  task automatic pause(input int n);
    for (int i = 0; i < n; i++) cyc(0, 4'd9, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0, 0, 0, 0);
    tests++; if ({c_locked, c_phase, c_lap_cnt, c_lap_done, c_cycle_done, c_err, c_err_code, c_err_cnt} !== 16'h0) begin
      fails++; $display("FAIL reset.outputs got %b %b %0d %b %b %b %0d %0d want all 0",
        c_locked, c_phase, c_lap_cnt, c_lap_done, c_cycle_done, c_err, c_err_code, c_err_cnt); end
  endtask

  task automatic test_golden();
    do_reset();
    pause(2);
    cyc(0, 4'd0, 1, 0);
    cyc(0, 4'd2, 1, 0);
    tests++; if (c_locked !== 1'b0) begin fails++; $display("FAIL golden.early_lock got %b want 0", c_locked); end
    cyc(0, 4'd4, 1, 0);
    tests++; if (c_locked !== 1'b1 || c_phase !== 1'b1) begin fails++; $display("FAIL golden.lock got %b/%b want 1/1", c_locked, c_phase); end
    cyc(0, 4'd5, 1, 1); cyc(0, 4'd7, 1, 1); cyc(0, 4'd9, 1, 1);
    lap(); lap();
    pause(3);
    tests++; if (c_locked !== 1'b1 || c_phase !== 1'b0 || c_lap_cnt !== 2'd0) begin
      fails++; $display("FAIL golden.pause got locked=%b phase=%b lap_cnt=%0d want 1 0 0", c_locked, c_phase, c_lap_cnt); end
    pause(9);
    lap();
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0);
    tests++; if (n_lap_done != 4) begin fails++; $display("FAIL golden.lap_done got %0d want 4", n_lap_done); end
    tests++; if (n_cycle_done != 1) begin fails++; $display("FAIL golden.cycle_done got %0d want 1", n_cycle_done); end
    tests++; if (n_err != 0 || c_err_cnt !== 8'd0) begin fails++; $display("FAIL golden.err got %0d cnt %0d want 0 0", n_err, c_err_cnt); end
    tests++; if (c_lap_cnt !== 2'd1 || c_phase !== 1'b1) begin fails++; $display("FAIL golden.lap_cnt got %0d phase %b want 1 1", c_lap_cnt, c_phase); end
  endtask

  task automatic test_val_err();
    do_reset();
    lap();
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0); cyc(0, 4'd6, 1, 0);
    cyc(0, 4'd5, 1, 1); cyc(0, 4'd7, 1, 1);
    tests++; if (c_err !== 1'b1 || c_err_code !== 2'd1 || c_locked !== 1'b0) begin
      fails++; $display("FAIL val_err.flag got err=%b code=%0d locked=%b want 1 1 0", c_err, c_err_code, c_locked); end
    tests++; if (c_lap_cnt !== 2'd1) begin fails++; $display("FAIL val_err.lap_hold got %0d want 1", c_lap_cnt); end
    cyc(0, 4'd9, 1, 1);
    tests++; if (c_err !== 1'b0 || c_err_cnt !== 8'd1 || c_locked !== 1'b0) begin
      fails++; $display("FAIL val_err.after got err=%b cnt=%0d locked=%b want 0 1 0", c_err, c_err_cnt, c_locked); end
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0); cyc(0, 4'd4, 1, 0);
    tests++; if (c_locked !== 1'b1 || c_lap_cnt !== 2'd0) begin
      fails++; $display("FAIL val_err.relock got locked=%b lap_cnt=%0d want 1 0", c_locked, c_lap_cnt); end
  endtask

  task automatic test_oe_err();
    do_reset();
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0); cyc(0, 4'd4, 1, 1);
    cyc(0, 4'd5, 1, 1); cyc(0, 4'd7, 1, 1);
    tests++; if (c_err !== 1'b1 || c_err_code !== 2'd2) begin
      fails++; $display("FAIL oe_err got err=%b code=%0d want 1 2", c_err, c_err_code); end
  endtask

  task automatic test_priority();
    do_reset();
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd4, 1, 1); cyc(0, 4'd4, 1, 1); cyc(0, 4'd5, 1, 1);
    tests++; if (c_err !== 1'b1 || c_err_code !== 2'd1) begin
      fails++; $display("FAIL priority got err=%b code=%0d want 1 1", c_err, c_err_code); end
  endtask

  task automatic test_early_en();
    do_reset();
    lap(); lap(); lap();
    pause(11);
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0); cyc(0, 4'd4, 1, 0);
    tests++; if (c_err !== 1'b1 || c_err_code !== 2'd3 || c_locked !== 1'b0) begin
      fails++; $display("FAIL early_en got err=%b code=%0d locked=%b want 1 3 0", c_err, c_err_code, c_locked); end
    cyc(0, 4'd5, 1, 1); cyc(0, 4'd7, 1, 1);
    tests++; if (n_cycle_done != 0) begin fails++; $display("FAIL early_en.cycle_done got %0d want 0", n_cycle_done); end
  endtask

  task automatic test_drop_en();
    do_reset();
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0); cyc(0, 4'd4, 1, 0);
    cyc(0, 4'd4, 0, 0); cyc(0, 4'd5, 1, 1); cyc(0, 4'd7, 1, 1);
    tests++; if (c_err !== 1'b1 || c_err_code !== 2'd3) begin
      fails++; $display("FAIL drop_en got err=%b code=%0d want 1 3", c_err, c_err_code); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 100; i++) begin cyc(0, 4'd0, 1, 0); cyc(0, 4'd5, 1, 0); end
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    tests++; if (c_err_cnt !== 8'd100) begin fails++; $display("FAIL saturate.mid got %0d want 100", c_err_cnt); end
    for (int i = 0; i < 200; i++) begin cyc(0, 4'd0, 1, 0); cyc(0, 4'd5, 1, 0); end
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    tests++; if (c_err_cnt !== 8'd255 || c_err_code !== 2'd1) begin
      fails++; $display("FAIL saturate.end got cnt=%0d code=%0d want 255 1", c_err_cnt, c_err_code); end
  endtask

  // Runs straight after saturation, so a working reset must clear err_cnt/err_code.
  task automatic test_mid_pause_reset();
    lap(); lap(); lap();
    pause(5);
    tests++; if (c_locked !== 1'b1 || c_phase !== 1'b0 || c_err_cnt !== 8'd255) begin
      fails++; $display("FAIL mid_reset.pre got locked=%b phase=%b cnt=%0d want 1 0 255", c_locked, c_phase, c_err_cnt); end
    cyc(1, 4'd9, 0, 1);
    cyc(0, 4'd9, 0, 1);
    tests++; if ({c_locked, c_phase, c_lap_cnt, c_lap_done, c_cycle_done, c_err, c_err_code, c_err_cnt} !== 16'h0) begin
      fails++; $display("FAIL mid_reset.clear got %b %b %0d %b %b %b %0d %0d want all 0",
        c_locked, c_phase, c_lap_cnt, c_lap_done, c_cycle_done, c_err, c_err_code, c_err_cnt); end
    pause(3);
    cyc(0, 4'd0, 1, 0); cyc(0, 4'd2, 1, 0);
    tests++; if (c_locked !== 1'b0) begin fails++; $display("FAIL mid_reset.idle got locked=%b want 0", c_locked); end
    cyc(0, 4'd4, 1, 0);
    tests++; if (c_locked !== 1'b1 || c_phase !== 1'b1) begin
      fails++; $display("FAIL mid_reset.relock got %b/%b want 1/1", c_locked, c_phase); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_val_err();
    test_oe_err();
    test_priority();
    test_early_en();
    test_drop_en();
    test_saturate();
    test_mid_pause_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
